mips_prog_loader: RTL and testbench

- Upstream companion to the two-phase `mips` pipeline core: accepts a framed byte stream and writes 32-bit words into the core's unified memory (`Mem`) through a write port.
- Holds the core parked until a complete, checksum-valid image has been written, then issues a one-cycle start pulse.
- The core uses that pulse to clear PC, HALTED and TAKEN_BRANCH.
- Replaces hierarchical memory pokes for program/data preload.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/byte_word_packer.sv | 45 ++++
 rtl/mips_prog_loader.sv | 179 +++++++++++++++++
 tb/tb_mips_prog_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the mips core and its program loader:
// loader state encoding, HLT opcode, default memory geometry and frame marker.
// No logic; constants and types only.
package mips_pkg;

  localparam int         MEM_AW        = 10;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [5:0] HLT           = 6'h3F;

  typedef enum logic [3:0] {
    IDLE,
    ADDR0,
    ADDR1,
    LEN0,
    LEN1,
    DATA,
    CHK,
    DONE,
    ERR
  } ld_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Big-endian 4-byte to 32-bit word assembler with a 2-bit byte counter.
// Latency: word_vld_o/word_dat_o are combinational with the 4th byte (0 cycles).
// Backpressure: none; the caller only presents bytes it has already accepted.
module byte_word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        word_vld_o,
  output logic [31:0] word_dat_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;

  // Next-state: clear wins; otherwise shift in one byte per valid beat
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clr_i) begin
      cnt_d = 2'd0;
      asm_d = 24'd0;
    end else if (byte_vld_i) begin
      cnt_d = cnt_q + 2'd1;
      asm_d = {asm_q[15:0], byte_dat_i};
    end
  end

  // Counter and the three most-significant bytes held so far
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      asm_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  // The 4th byte completes the word in the same cycle it arrives
  assign word_vld_o = byte_vld_i && !clr_i && (cnt_q == 2'd3);
  assign word_dat_o = {asm_q, byte_dat_i};

endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader writing 32-bit words into the core memory, then releasing the core.
// Latency: a word is written the cycle after its 4th byte; start pulse the cycle after the CHK byte.
// Backpressure: s_ready drops only for the single DONE/ERR cycle. MIPS_LOADER_HALT_CHECK_EN adds HLT check.
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int         AW        = MEM_AW,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_hold,
  output logic          core_start,
  output logic          load_done,
  output logic          load_err,
  output logic [15:0]   words_written
);

  ld_state_e     state_q;
  logic          s_ready_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          core_hold_q;
  logic          core_start_q;
  logic          load_done_q;
  logic          load_err_q;
  logic [15:0]   words_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    addr_hi_q;
  logic [7:0]    len_hi_q;
  logic [15:0]   len_q;
  logic [7:0]    xor_q;
`ifdef MIPS_LOADER_HALT_CHECK_EN
  logic          hlt_q;
`endif

  logic          acc_d;
  logic          sync_d;
  logic          pk_word_vld;
  logic [31:0]   pk_word;
  logic [15:0]   words_d;
  logic          chk_ok_d;

  assign acc_d   = s_valid && s_ready_q;
  assign sync_d  = acc_d && (state_q == IDLE) && (s_data == SYNC_BYTE);
  assign words_d = words_q + 16'd1;

`ifdef MIPS_LOADER_HALT_CHECK_EN
  assign chk_ok_d = (s_data == xor_q) && hlt_q;
`else
  assign chk_ok_d = (s_data == xor_q);
`endif

  byte_word_packer u_packer (
    .clk_i      (clk1),
    .rst_ni     (rst_n),
    .clr_i      (sync_d),
    .byte_vld_i (acc_d && (state_q == DATA)),
    .byte_dat_i (s_data),
    .word_vld_o (pk_word_vld),
    .word_dat_o (pk_word)
  );

  // Frame FSM with registered outputs, checksum, address and word counting
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      core_hold_q  <= 1'b1;
      core_start_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      words_q      <= 16'd0;
      addr_q       <= '0;
      addr_hi_q    <= 8'd0;
      len_hi_q     <= 8'd0;
      len_q        <= 16'd0;
      xor_q        <= 8'd0;
`ifdef MIPS_LOADER_HALT_CHECK_EN
      hlt_q        <= 1'b0;
`endif
    end else begin
      mem_we_q     <= 1'b0;
      core_start_q <= 1'b0;

      // Completed words commit immediately; a later bad checksum does not undo them
      if (pk_word_vld) begin
        mem_we_q    <= 1'b1;
        mem_wdata_q <= pk_word;
        mem_addr_q  <= addr_q;
        addr_q      <= addr_q + AW'(1);
        words_q     <= words_d;
`ifdef MIPS_LOADER_HALT_CHECK_EN
        if (pk_word[31:26] == HLT) hlt_q <= 1'b1;
`endif
      end

      case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
          if (sync_d) begin
            state_q     <= ADDR0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            words_q     <= 16'd0;
            core_hold_q <= 1'b1;
            xor_q       <= 8'd0;
`ifdef MIPS_LOADER_HALT_CHECK_EN
            hlt_q       <= 1'b0;
`endif
          end
        end
        ADDR0: if (acc_d) begin
          addr_hi_q <= s_data;
          xor_q     <= xor_q ^ s_data;
          state_q   <= ADDR1;
        end
        ADDR1: if (acc_d) begin
          // Only the low AW bits of the 16-bit start address select a word
          addr_q  <= AW'({addr_hi_q, s_data});
          xor_q   <= xor_q ^ s_data;
          state_q <= LEN0;
        end
        LEN0: if (acc_d) begin
          len_hi_q <= s_data;
          xor_q    <= xor_q ^ s_data;
          state_q  <= LEN1;
        end
        LEN1: if (acc_d) begin
          len_q   <= {len_hi_q, s_data};
          xor_q   <= xor_q ^ s_data;
          state_q <= ({len_hi_q, s_data} == 16'd0) ? CHK : DATA;
        end
        DATA: if (acc_d) begin
          xor_q <= xor_q ^ s_data;
          if (pk_word_vld && (words_d == len_q)) state_q <= CHK;
        end
        CHK: if (acc_d) begin
          s_ready_q <= 1'b0;
          if (chk_ok_d) begin
            state_q      <= DONE;
            core_start_q <= 1'b1;
            core_hold_q  <= 1'b0;
            load_done_q  <= 1'b1;
          end else begin
            state_q    <= ERR;
            load_err_q <= 1'b1;
          end
        end
        DONE, ERR: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready       = s_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign core_hold     = core_hold_q;
  assign core_start    = core_start_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: good image, bad checksum, garbage + empty frame,
// address wrap with stalls, mid-frame reset followed by a clean reload.
module tb_mips_prog_loader;

`ifdef MIPS_LOADER_HALT_CHECK_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        core_start;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_written;

  mips_prog_loader dut (
    .clk1          (clk1),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .core_hold     (core_hold),
    .core_start    (core_start),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  always #5 clk1 = ~clk1;

  int tests = 0;
  int fails = 0;

  // Write and start-pulse recorder, sampled mid-cycle
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          start_cnt = 0;
  always @(negedge clk1) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (core_start) start_cnt++;
  end

  logic [31:0] img[$];
  logic [7:0]  fb[$];
  int          wbase;
  int          sbase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte at a negedge and hold it until a ready edge takes it
  task automatic send_byte(input logic [7:0] b);
    bit   taken;
    logic r;
    taken = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 64 && !taken; i++) begin
      r = s_ready;
      @(posedge clk1);
      if (r) taken = 1'b1;
      @(negedge clk1);
    end
    if (!taken) begin
      tests++;
      fails++;
      $error("FAIL handshake_timeout: observed no ready expected ready for byte %h", b);
    end
  endtask

  task automatic build_frame(input logic [15:0] addr, input bit flip);
    logic [7:0]  x;
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(img.size());
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(addr[15:8]);
    fb.push_back(addr[7:0]);
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    foreach (img[i]) begin
      w = img[i];
      for (int k = 3; k >= 0; k--) fb.push_back(w[8*k +: 8]);
    end
    x = 8'd0;
    for (int i = 1; i < fb.size(); i++) x = x ^ fb[i];
    fb.push_back(flip ? (x ^ 8'h01) : x);
  endtask

  task automatic send_bytes(input int cnt, input bit toggle);
    for (int i = 0; i < cnt; i++) begin
      send_byte(fb[i]);
      if (toggle) begin
        s_valid = 1'b0;
        @(negedge clk1);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [9:0] base);
    check({tag, "_nwr"}, 32'(wr_addr.size() - wbase), 32'(img.size()));
    for (int i = 0; i < img.size() && (wbase + i) < wr_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr[wbase + i]), 32'(base + 10'(i)));
      check({tag, "_data"}, wr_data[wbase + i], img[i]);
    end
  endtask

  task automatic mark();
    wbase = wr_addr.size();
    sbase = start_cnt;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk1);
  endtask

  task automatic load_prog();
    img.delete();
    img.push_back(32'h28010078); img.push_back(32'h0C631800);
    img.push_back(32'h20220000); img.push_back(32'h0C631800);
    img.push_back(32'h2842002D); img.push_back(32'h0C631800);
    img.push_back(32'h24220001); img.push_back(32'hFC000000);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"},    32'(s_ready), 32'd0);
    check({tag, "_mem_we"},     32'(mem_we), 32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"},  mem_wdata, 32'd0);
    check({tag, "_core_hold"},  32'(core_hold), 32'd1);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_load_done"},  32'(load_done), 32'd0);
    check({tag, "_load_err"},   32'(load_err), 32'd0);
    check({tag, "_words"},      32'(words_written), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk1);
    check("rst_ready_after", 32'(s_ready), 32'd1);

    // 1: 8-word image at address 0, good checksum
    load_prog();
    mark();
    build_frame(16'h0000, 1'b0);
    send_bytes(fb.size(), 1'b0);
    settle();
    check_writes("t1", 10'h000);
    check("t1_words",  32'(words_written), 32'd8);
    check("t1_start",  32'(start_cnt - sbase), 32'd1);
    check("t1_hold",   32'(core_hold), 32'd0);
    check("t1_done",   32'(load_done), 32'd1);
    check("t1_err",    32'(load_err), 32'd0);

    // 2: same frame, checksum bit 0 flipped
    mark();
    build_frame(16'h0000, 1'b1);
    send_bytes(fb.size(), 1'b0);
    settle();
    check_writes("t2", 10'h000);
    check("t2_words",  32'(words_written), 32'd8);
    check("t2_start",  32'(start_cnt - sbase), 32'd0);
    check("t2_hold",   32'(core_hold), 32'd1);
    check("t2_done",   32'(load_done), 32'd0);
    check("t2_err",    32'(load_err), 32'd1);

    // 3: garbage then empty frame at 0x0010; CHK = 00^10^00^00 = 10
    mark();
    fb.delete();
    fb.push_back(8'h00); fb.push_back(8'hFF); fb.push_back(8'h13);
    fb.push_back(8'hA5); fb.push_back(8'h00); fb.push_back(8'h10);
    fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h10);
    send_bytes(fb.size(), 1'b0);
    settle();
    check("t3_nwr",   32'(wr_addr.size() - wbase), 32'd0);
    check("t3_words", 32'(words_written), 32'd0);
    check("t3_done",  32'(load_done), HC ? 32'd0 : 32'd1);
    check("t3_err",   32'(load_err), HC ? 32'd1 : 32'd0);
    check("t3_start", 32'(start_cnt - sbase), HC ? 32'd0 : 32'd1);
    check("t3_hold",  32'(core_hold), HC ? 32'd1 : 32'd0);

    // 4: start at 0x3FF, two words, s_valid toggled: wraps to 0x000
    img.delete();
    img.push_back(32'h11223344);
    img.push_back(32'h55667788);
    mark();
    build_frame(16'h03FF, 1'b0);
    send_bytes(fb.size(), 1'b1);
    settle();
    check("t4_nwr",   32'(wr_addr.size() - wbase), 32'd2);
    if (wr_addr.size() - wbase >= 2) begin
      check("t4_addr0", 32'(wr_addr[wbase]),     32'h3FF);
      check("t4_data0", wr_data[wbase],          32'h11223344);
      check("t4_addr1", 32'(wr_addr[wbase + 1]), 32'h000);
      check("t4_data1", wr_data[wbase + 1],      32'h55667788);
    end
    check("t4_words", 32'(words_written), 32'd2);
    check("t4_done",  32'(load_done), HC ? 32'd0 : 32'd1);
    check("t4_start", 32'(start_cnt - sbase), HC ? 32'd0 : 32'd1);

    // 5: reset after 2nd byte of 3rd word at 0x0020, then clean reload at 0x0100
    img.delete();
    img.push_back(32'hA0A1A2A3); img.push_back(32'hB0B1B2B3);
    img.push_back(32'hC0C1C2C3); img.push_back(32'hD0D1D2D3);
    mark();
    build_frame(16'h0020, 1'b0);
    send_bytes(5 + 8 + 2, 1'b0);
    @(negedge clk1);
    check("t5_words_pre", 32'(words_written), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_rst");
    check("t5_nwr", 32'(wr_addr.size() - wbase), 32'd2);
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    load_prog();
    mark();
    build_frame(16'h0100, 1'b0);
    send_bytes(fb.size(), 1'b0);
    settle();
    check_writes("t5", 10'h100);
    check("t5_words", 32'(words_written), 32'd8);
    check("t5_start", 32'(start_cnt - sbase), 32'd1);
    check("t5_done",  32'(load_done), 32'd1);
    check("t5_hold",  32'(core_hold), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
